axis_datapoint_receiver: RTL

- AXI4-Stream slave ingress block for the inference wrapper.
- Accepts 64-bit beats from the host DMA and groups each run of NUM_PACKETS consecutive beats into one datapoint vector.
- Presents each vector to the core through a registered valid/ready interface.
- Checks frame framing: tlast must arrive on the final beat of datapoint DATAPOINTS-1. Sticky error flags record violations.

---
 rtl/axis_datapoint_receiver.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/axis_datapoint_receiver.sv
// Purpose : AXI4-Stream slave that packs NUM_PACKETS beats into one datapoint and checks tlast framing.
// Latency : dp_valid rises 1 cycle after the final beat handshake of a datapoint.
// Backpr. : tready drops only on the final beat of a datapoint while the previous one is still unconsumed.
//
// Ports:
//   s00_axis_aclk / s00_axis_aresetn : clock, async active-low reset
//   s00_axis_t*                      : AXI4-Stream slave (tdata, tstrb, tlast, tvalid, tready)
//   dp_data/dp_valid/dp_ready        : assembled datapoint, registered valid/ready
//   dp_last/dp_index                 : last-of-frame marker and datapoint number within the frame
//   frame_done                       : one-cycle pulse on a correctly framed frame end
//   err_strb/err_early_last/err_missing_last, err_clear : sticky framing/strobe errors and their clear
module axis_datapoint_receiver #(
    parameter int C_S00_AXIS_DATA_WIDTH = 64,
    parameter int NUM_PACKETS           = 13,
    parameter int DATAPOINTS            = 100,
    localparam int W  = C_S00_AXIS_DATA_WIDTH,
    localparam int DW = NUM_PACKETS * C_S00_AXIS_DATA_WIDTH,
    localparam int BW = (NUM_PACKETS > 1) ? $clog2(NUM_PACKETS) : 1,
    localparam int IW = (DATAPOINTS > 1) ? $clog2(DATAPOINTS) : 1
) (
    input  logic              s00_axis_aclk,
    input  logic              s00_axis_aresetn,
    input  logic [W-1:0]      s00_axis_tdata,
    input  logic [W/8-1:0]    s00_axis_tstrb,
    input  logic              s00_axis_tlast,
    input  logic              s00_axis_tvalid,
    output logic              s00_axis_tready,
    output logic [DW-1:0]     dp_data,
    output logic              dp_valid,
    input  logic              dp_ready,
    output logic              dp_last,
    output logic [IW-1:0]     dp_index,
    output logic              frame_done,
    output logic              err_strb,
    output logic              err_early_last,
    output logic              err_missing_last,
    input  logic              err_clear
);

    logic [BW-1:0] beat_cnt_q, beat_cnt_d;
    logic [IW-1:0] dp_cnt_q, dp_cnt_d;
    logic [DW-1:0] asm_q, asm_d, asm_merged;
    logic [DW-1:0] dp_data_q, dp_data_d;
    logic          dp_valid_q, dp_valid_d;
    logic          dp_last_q, dp_last_d;
    logic [IW-1:0] dp_index_q, dp_index_d;
    logic          frame_done_q, frame_done_d;
    logic          err_strb_q, err_strb_d;
    logic          err_early_q, err_early_d;
    logic          err_missing_q, err_missing_d;
    // Keeps tready low while reset is held and until the first edge after release.
    logic          en_q;

    logic last_beat, last_dp, exp_last, stall, beat_acc, early, complete;

    always_comb begin
        last_beat = (beat_cnt_q == BW'(NUM_PACKETS - 1));
        last_dp   = (dp_cnt_q == IW'(DATAPOINTS - 1));
        exp_last  = last_beat && last_dp;
        // Only the closing beat needs the output register free; earlier beats land in asm_q.
        stall     = last_beat && dp_valid_q && !dp_ready;
        s00_axis_tready = en_q && !stall;
        beat_acc  = s00_axis_tvalid && s00_axis_tready;
        early     = beat_acc && s00_axis_tlast && !exp_last;
        complete  = beat_acc && last_beat && !early;
    end

    always_comb begin
        asm_merged = asm_q;
        asm_merged[int'(beat_cnt_q) * W +: W] = s00_axis_tdata;
    end

    always_comb begin
        beat_cnt_d    = beat_cnt_q;
        dp_cnt_d      = dp_cnt_q;
        asm_d         = asm_q;
        dp_data_d     = dp_data_q;
        dp_valid_d    = dp_valid_q;
        dp_last_d     = dp_last_q;
        dp_index_d    = dp_index_q;
        frame_done_d  = 1'b0;

        if (beat_acc) begin
            asm_d = asm_merged;
        end

        if (early) begin
            // Partial datapoint is dropped; a pending output stays untouched.
            beat_cnt_d = '0;
            dp_cnt_d   = '0;
        end else if (beat_acc) begin
            beat_cnt_d = last_beat ? '0 : beat_cnt_q + BW'(1);
        end

        if (complete) begin
            dp_cnt_d     = last_dp ? '0 : dp_cnt_q + IW'(1);
            dp_data_d    = asm_merged;
            dp_valid_d   = 1'b1;
            dp_index_d   = dp_cnt_q;
            dp_last_d    = last_dp;
            frame_done_d = exp_last && s00_axis_tlast;
        end else if (dp_valid_q && dp_ready) begin
            dp_valid_d = 1'b0;
        end

        // Set has priority over a same-cycle clear.
        err_strb_d    = (err_strb_q && !err_clear) ||
                        (beat_acc && (s00_axis_tstrb != '1));
        err_early_d   = (err_early_q && !err_clear) || early;
        err_missing_d = (err_missing_q && !err_clear) ||
                        (complete && exp_last && !s00_axis_tlast);
    end

    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            en_q          <= 1'b0;
            beat_cnt_q    <= '0;
            dp_cnt_q      <= '0;
            asm_q         <= '0;
            dp_data_q     <= '0;
            dp_valid_q    <= 1'b0;
            dp_last_q     <= 1'b0;
            dp_index_q    <= '0;
            frame_done_q  <= 1'b0;
            err_strb_q    <= 1'b0;
            err_early_q   <= 1'b0;
            err_missing_q <= 1'b0;
        end else begin
            en_q          <= 1'b1;
            beat_cnt_q    <= beat_cnt_d;
            dp_cnt_q      <= dp_cnt_d;
            asm_q         <= asm_d;
            dp_data_q     <= dp_data_d;
            dp_valid_q    <= dp_valid_d;
            dp_last_q     <= dp_last_d;
            dp_index_q    <= dp_index_d;
            frame_done_q  <= frame_done_d;
            err_strb_q    <= err_strb_d;
            err_early_q   <= err_early_d;
            err_missing_q <= err_missing_d;
        end
    end

    assign dp_data          = dp_data_q;
    assign dp_valid         = dp_valid_q;
    assign dp_last          = dp_last_q;
    assign dp_index         = dp_index_q;
    assign frame_done       = frame_done_q;
    assign err_strb         = err_strb_q;
    assign err_early_last   = err_early_q;
    assign err_missing_last = err_missing_q;

endmodule
